// File: rtl/softmax_pkg.sv
`default_nettype none
//============================================================================
// Module   : softmax_pkg
// Purpose  : Shared sizing constants, packed vector type and FSM state
//            encoding for the softmax input server and its vector RAM.
// Ports    : none (package)
// Revision : 1.0 - initial release
//============================================================================
package softmax_pkg;

    localparam int DATAWIDTH    = 16;
    localparam int NUM          = 4;
    localparam int ADDRSIZE     = 8;
    localparam int VECWIDTH     = DATAWIDTH * NUM;
    localparam int DEPTH        = 2 ** ADDRSIZE;
    localparam int NUM_RD_PORTS = 3;

    // Packed vector word, element 0 in the LSBs.
    typedef logic [VECWIDTH-1:0] vec_t;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_START = 2'd1,
        ST_SERVE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/softmax_vec_ram.sv
`default_nettype none
//============================================================================
// Module   : softmax_vec_ram
// Purpose  : Vector scratchpad with one write port and NUM_RD_PORTS
//            independent registered read ports (1-cycle latency). The array
//            itself is not reset; only the read data registers are.
// Ports    : clk, reset      - clock, async active-high reset
//            wr_en/addr/data - write port
//            rd_en[p]        - read enable; a disabled port registers zero
//            rd_addr[p]      - read address per port
//            rd_data[p]      - registered read data per port
// Revision : 1.0 - initial release
//============================================================================
module softmax_vec_ram
    import softmax_pkg::*;
(
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   wr_en,
    input  logic [ADDRSIZE-1:0]                    wr_addr,
    input  vec_t                                   wr_data,
    input  logic [NUM_RD_PORTS-1:0]                rd_en,
    input  logic [NUM_RD_PORTS-1:0][ADDRSIZE-1:0]  rd_addr,
    output logic [NUM_RD_PORTS-1:0][VECWIDTH-1:0]  rd_data
);

    vec_t r_mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    generate
        for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd_port
            vec_t r_q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_q <= '0;
                end else if (rd_en[p]) begin
                    r_q <= r_mem[rd_addr[p]];
                end else begin
                    r_q <= '0;
                end
            end

            assign rd_data[p] = r_q;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/softmax_inp_server.sv
`default_nettype none
//============================================================================
// Module   : softmax_inp_server
// Purpose  : Loads packed input vectors from a host, then serves the softmax
//            engine's three read-address streams with 1-cycle registered data.
//            Publishes addr_limit and pulses start_max to launch the engine.
// Ports    : clk, reset                 - clock, async active-high reset
//            wr_en, wr_data, wr_last    - host load stream
//            wr_ready                   - high while loading
//            clear                      - return to loading (SERVE only)
//            addr_limit                 - index of last loaded word
//            start_max                  - one-cycle engine launch pulse
//            busy                       - high in START and SERVE
//            addr, sub0/sub1_inp_addr   - engine read addresses
//            inp, sub0_inp, sub1_inp    - matching read data
// Revision : 1.0 - initial release
//============================================================================
module softmax_inp_server
    import softmax_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  vec_t                wr_data,
    input  logic                wr_last,
    output logic                wr_ready,
    input  logic                clear,
    output logic [ADDRSIZE-1:0] addr_limit,
    output logic                start_max,
    output logic                busy,
    input  logic [ADDRSIZE-1:0] addr,
    input  logic [ADDRSIZE-1:0] sub0_inp_addr,
    input  logic [ADDRSIZE-1:0] sub1_inp_addr,
    output vec_t                inp,
    output vec_t                sub0_inp,
    output vec_t                sub1_inp
);

    localparam logic [ADDRSIZE-1:0] c_ptr_full = '1;

    state_t                                 r_state;
    state_t                                 w_next_state;
    logic [ADDRSIZE-1:0]                    r_wr_ptr;
    logic [ADDRSIZE-1:0]                    r_addr_limit;
    logic                                   w_wr_accept;
    logic                                   w_load_done;
    logic [NUM_RD_PORTS-1:0]                w_rd_en;
    logic [NUM_RD_PORTS-1:0][ADDRSIZE-1:0]  w_rd_addr;
    logic [NUM_RD_PORTS-1:0][VECWIDTH-1:0]  w_rd_data;

    assign w_wr_accept = (r_state == ST_LOAD) && wr_en;
    // A load ends on an explicit wr_last or when the final address is written.
    assign w_load_done = w_wr_accept && (wr_last || (r_wr_ptr == c_ptr_full));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_LOAD:  if (w_load_done) w_next_state = ST_START;
            ST_START: w_next_state = ST_SERVE;
            ST_SERVE: if (clear) w_next_state = ST_LOAD;
            default:  w_next_state = ST_LOAD;
        endcase
    end

    // Output logic
    always_comb begin
        wr_ready  = 1'b0;
        start_max = 1'b0;
        busy      = 1'b0;
        case (r_state)
            ST_LOAD:  wr_ready = 1'b1;
            ST_START: begin
                start_max = 1'b1;
                busy      = 1'b1;
            end
            ST_SERVE: busy = 1'b1;
            default:  wr_ready = 1'b1;
        endcase
    end

    // Write pointer and published limit. addr_limit only changes when a load
    // completes, so it stays valid through a clear until the next load ends.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_addr_limit <= '0;
        end else begin
            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + ADDRSIZE'(1);
            end else if ((r_state == ST_SERVE) && clear) begin
                r_wr_ptr <= '0;
            end
            if (w_load_done) begin
                r_addr_limit <= r_wr_ptr;
            end
        end
    end

    assign addr_limit = r_addr_limit;

    // Port 0 = main, 1 = sub0, 2 = sub1. Reads past addr_limit (the engine
    // reads one beyond) and reads outside SERVE return zero, which also hides
    // stale array contents from earlier loads.
    assign w_rd_addr = {sub1_inp_addr, sub0_inp_addr, addr};

    generate
        for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd_gate
            assign w_rd_en[p] = (r_state == ST_SERVE) && (w_rd_addr[p] <= r_addr_limit);
        end
    endgenerate

    softmax_vec_ram u_ram (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (w_wr_accept),
        .wr_addr (r_wr_ptr),
        .wr_data (wr_data),
        .rd_en   (w_rd_en),
        .rd_addr (w_rd_addr),
        .rd_data (w_rd_data)
    );

    assign inp      = w_rd_data[0];
    assign sub0_inp = w_rd_data[1];
    assign sub1_inp = w_rd_data[2];

endmodule
`default_nettype wire
